branch_history_unit: RTL and testbench

//  Front end of the branch direction predictor: generates the lookup index for the pattern history table,

---
 rtl/branch_history_unit.sv | 135 +++++++++++++
 tb/tb_branch_history_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_history_unit.sv
// Global-history front end for the branch direction predictor: forms the PHT lookup index, tracks
// speculative/committed GHRs and queues in-flight predictions. Optional counters under BHU_STATS_EN.
module branch_history_unit #(
  parameter int HIST_W = 10,
  parameter int DEPTH  = 4,
  parameter int PC_LSB = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic [31:0]              pred_pc,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  output logic [HIST_W-1:0]        pht_addr,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     upd_valid,
  output logic [HIST_W-1:0]        upd_index,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   inflight
`ifdef BHU_STATS_EN
  ,
  output logic [31:0]              stat_branches,
  output logic [31:0]              stat_mispred
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [HIST_W-1:0] spec_ghr_reg;
  logic [HIST_W-1:0] com_ghr_reg;
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;

  logic [HIST_W-1:0] idx_mem [DEPTH];
  logic              pred_mem [DEPTH];

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic flush;
  logic head_pred;

  // Only the index window of the PC and the low HIST_W-1 committed bits feed any logic.
  logic unused_bits;
  assign unused_bits = ^{pred_pc, com_ghr_reg[HIST_W-1]};

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CNT_W'(DEPTH));
  assign pred_ready = ~full;
  assign inflight   = count_reg;
  assign pht_addr   = pred_pc[PC_LSB+HIST_W-1:PC_LSB] ^ spec_ghr_reg;

  assign head_pred  = pred_mem[head_reg];
  assign pop        = res_valid & ~empty;
  // A wrong head prediction means every younger entry was fetched down the wrong path.
  assign flush      = pop & (head_pred != res_taken);
  assign push       = pred_valid & pred_ready & ~flush;

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[tail_reg]  <= pht_addr;
      pred_mem[tail_reg] <= pred_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_ghr_reg <= '0;
      com_ghr_reg  <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      upd_valid    <= 1'b0;
      upd_index    <= '0;
      upd_taken    <= 1'b0;
      mispredict   <= 1'b0;
    end else begin
      count_reg  <= count_next;
      upd_valid  <= pop;
      mispredict <= flush;
      if (pop) begin
        upd_index   <= idx_mem[head_reg];
        upd_taken   <= res_taken;
        com_ghr_reg <= {com_ghr_reg[HIST_W-2:0], res_taken};
      end
      if (flush) begin
        head_reg     <= '0;
        tail_reg     <= '0;
        spec_ghr_reg <= {com_ghr_reg[HIST_W-2:0], res_taken};
      end else begin
        if (push) begin
          tail_reg     <= tail_reg + 1'b1;
          spec_ghr_reg <= {spec_ghr_reg[HIST_W-2:0], pred_taken};
        end
        if (pop) begin
          head_reg <= head_reg + 1'b1;
        end
      end
    end
  end

`ifdef BHU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (pop && stat_branches != 32'hFFFF_FFFF) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (flush && stat_mispred != 32'hFFFF_FFFF) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_history_unit.sv
// Directed bench for branch_history_unit: vector table plus hand-written reset/flush sequences.
// Stats checks are active when BHU_STATS_EN is defined.
module tb_branch_history_unit;

  logic        clk;
  logic        rst_n;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        pred_ready;
  logic [9:0]  pht_addr;
  logic        res_valid;
  logic        res_taken;
  logic        upd_valid;
  logic [9:0]  upd_index;
  logic        upd_taken;
  logic        mispredict;
  logic [2:0]  inflight;
`ifdef BHU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  int errors = 0;
  int checks = 0;

  branch_history_unit #(.HIST_W(10), .DEPTH(4), .PC_LSB(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pred_valid (pred_valid),
    .pred_pc    (pred_pc),
    .pred_taken (pred_taken),
    .pred_ready (pred_ready),
    .pht_addr   (pht_addr),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .upd_valid  (upd_valid),
    .upd_index  (upd_index),
    .upd_taken  (upd_taken),
    .mispredict (mispredict),
    .inflight   (inflight)
`ifdef BHU_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        pt;
    logic        rv;
    logic        rt;
    logic        e_ready;
    logic [9:0]  e_pht;
    logic [2:0]  e_inflight;
    logic        e_uv;
    logic [9:0]  e_uidx;
    logic        e_ut;
    logic        e_misp;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic pt,
                       input logic rv, input logic rt);
    pred_valid = pv;
    pred_pc    = pc;
    pred_taken = pt;
    res_valid  = rv;
    res_taken  = rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            pv  pc            pt   rv   rt   rdy  pht     inf   uv   uidx    ut   misp
    vecs[0]  = '{1'b1, 32'h040, 1'b1, 1'b0, 1'b0, 1'b1, 10'h010, 3'd0, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h001, 3'd1, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 10'h041, 3'd1, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h003, 3'd2, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'hFFC, 1'b1, 1'b0, 1'b0, 1'b1, 10'h3F9, 3'd3, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h00D, 3'd4, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h00D, 3'd4, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 1'b0, 10'h00D, 3'd4, 1'b1, 10'h010, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h00D, 3'd3, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h000, 1'b1, 1'b1, 1'b1, 1'b1, 10'h00D, 3'd3, 1'b1, 10'h041, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h01B, 3'd3, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'h000, 1'b0, 1'b1, 1'b1, 1'b1, 10'h01B, 3'd3, 1'b1, 10'h003, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h007, 3'd0, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h007, 3'd0, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 32'h000, 1'b1, 1'b0, 1'b0, 1'b1, 10'h007, 3'd0, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 32'h000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h00F, 3'd1, 1'b1, 10'h007, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h00E, 3'd0, 1'b0, 10'h000, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check("reset_ready", 32'(pred_ready), 32'd1);
    check("reset_inflight", 32'(inflight), 32'd0);
    check("reset_pht", 32'(pht_addr), 32'h000);
    check("reset_upd_valid", 32'(upd_valid), 32'd0);
    check("reset_upd_index", 32'(upd_index), 32'd0);
    check("reset_mispredict", 32'(mispredict), 32'd0);
    $display("txn reset: ready=%0d inflight=%0d", pred_ready, inflight);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].pv, vecs[i].pc, vecs[i].pt, vecs[i].rv, vecs[i].rt);
      #1;
      check($sformatf("v%0d_ready", i), 32'(pred_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d_pht", i), 32'(pht_addr), 32'(vecs[i].e_pht));
      check($sformatf("v%0d_inflight", i), 32'(inflight), 32'(vecs[i].e_inflight));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_upd_valid", i), 32'(upd_valid), 32'(vecs[i].e_uv));
      check($sformatf("v%0d_mispredict", i), 32'(mispredict), 32'(vecs[i].e_misp));
      if (vecs[i].e_uv) begin
        check($sformatf("v%0d_upd_index", i), 32'(upd_index), 32'(vecs[i].e_uidx));
        check($sformatf("v%0d_upd_taken", i), 32'(upd_taken), 32'(vecs[i].e_ut));
      end
`ifdef BHU_STATS_EN
      if (i == 12) begin
        check("stat_branches_3", stat_branches, 32'd3);
        check("stat_mispred_1", stat_mispred, 32'd1);
      end
`endif
      $display("txn v%0d: pv=%0d pc=%h rv=%0d rt=%0d -> uv=%0d uidx=%h misp=%0d inflight=%0d",
               i, vecs[i].pv, vecs[i].pc, vecs[i].rv, vecs[i].rt, upd_valid, upd_index,
               mispredict, inflight);
    end

    // Asynchronous reset while an update pulse is on the outputs and entries are in flight.
    drive(1'b1, 32'h040, 1'b1, 1'b0, 1'b0);
    #1 check("seqA_push_pht", 32'(pht_addr), 32'h01E);
    tick();
    drive(1'b1, 32'h000, 1'b1, 1'b0, 1'b0);
    #1 check("seqA_push2_pht", 32'(pht_addr), 32'h01D);
    tick();
    drive(1'b0, 32'h000, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h000, 1'b0, 1'b0, 1'b0);
    check("seqA_upd_valid", 32'(upd_valid), 32'd1);
    check("seqA_upd_index", 32'(upd_index), 32'h01E);
    #2 rst_n = 1'b0;
    #1;
    check("seqA_rst_upd_valid", 32'(upd_valid), 32'd0);
    check("seqA_rst_upd_index", 32'(upd_index), 32'd0);
    check("seqA_rst_inflight", 32'(inflight), 32'd0);
    check("seqA_rst_pht", 32'(pht_addr), 32'h000);
    check("seqA_rst_ready", 32'(pred_ready), 32'd1);
    $display("txn async reset: uv=%0d uidx=%h inflight=%0d", upd_valid, upd_index, inflight);
    tick();
    rst_n = 1'b1;
    tick();

    // Three pushes (1,1,0), then the head resolves not-taken: flush back to committed history.
    drive(1'b1, 32'h000, 1'b1, 1'b0, 1'b0);
    #1 check("seqB_p1_pht", 32'(pht_addr), 32'h000);
    tick();
    drive(1'b1, 32'h000, 1'b1, 1'b0, 1'b0);
    #1 check("seqB_p2_pht", 32'(pht_addr), 32'h001);
    tick();
    drive(1'b1, 32'h000, 1'b0, 1'b0, 1'b0);
    #1 check("seqB_p3_pht", 32'(pht_addr), 32'h003);
    tick();
    check("seqB_inflight3", 32'(inflight), 32'd3);
    drive(1'b0, 32'h000, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h000, 1'b0, 1'b0, 1'b0);
    #1;
    check("seqB_mispredict", 32'(mispredict), 32'd1);
    check("seqB_upd_valid", 32'(upd_valid), 32'd1);
    check("seqB_upd_index", 32'(upd_index), 32'h000);
    check("seqB_upd_taken", 32'(upd_taken), 32'd0);
    check("seqB_inflight0", 32'(inflight), 32'd0);
    check("seqB_spec_ghr", 32'(pht_addr), 32'h000);
`ifdef BHU_STATS_EN
    check("seqB_stat_branches", stat_branches, 32'd1);
    check("seqB_stat_mispred", stat_mispred, 32'd1);
`endif
    $display("txn flush: misp=%0d inflight=%0d pht=%h", mispredict, inflight, pht_addr);
    tick();
    check("seqB_misp_pulse", 32'(mispredict), 32'd0);
    check("seqB_uv_pulse", 32'(upd_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
